load_store_unit: RTL

Multi-cycle load/store initiator that sits between the core's memory stage and a byte-wide data-memory port. It accepts one byte, halfword or word access from the core and issues it as a sequence of single-byte transactions over a valid/ready bus. For loads it assembles the bytes little-endian and sign- or zero-extends the result; for stores it serialises the write data. It replaces direct combinational access to data memory once that memory becomes a shared, stallable resource.

---
 rtl/load_store_unit.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Byte-serial load/store initiator: splits core byte/half/word accesses into 8-bit bus transfers.
// Optional build macro LSU_MISALIGN_TRAP_EN rejects misaligned halfword/word accesses.
module load_store_unit #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wd,
    input  logic [1:0]        i_mask_type,
    input  logic              i_ext_type,
    output logic              o_busy,
    output logic              o_done,
    output logic [31:0]       o_rd,
    output logic              o_misaligned,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_wdata,
    input  logic              i_mem_ready,
    input  logic [7:0]        i_mem_rdata
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    localparam logic [1:0] MaskByte = 2'b00;
    localparam logic [1:0] MaskHalf = 2'b01;
    localparam logic [1:0] MaskWord = 2'b10;
    localparam logic [1:0] MaskBad  = 2'b11;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [31:0]       wd_q, wd_d;
    logic [1:0]        mask_q, mask_d;
    logic              ext_q, ext_d;
    logic [1:0]        k_q, k_d;
    logic [31:0]       asm_q, asm_d;
    logic [31:0]       rd_q, rd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              last_byte;
    logic              trap;

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_q, mis_d;
    assign trap = ((i_mask_type == MaskHalf) && i_addr[0]) ||
                  ((i_mask_type == MaskWord) && (i_addr[1:0] != 2'b00));
    assign o_misaligned = mis_q;
`else
    assign trap         = 1'b0;
    assign o_misaligned = 1'b0;
`endif

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] mask,
                                           input logic zext);
        case (mask)
            MaskByte: extend = {{24{~zext & raw[7]}}, raw[7:0]};
            MaskHalf: extend = {{16{~zext & raw[15]}}, raw[15:0]};
            default:  extend = raw;
        endcase
    endfunction

    always_comb begin
        case (mask_q)
            MaskByte: last_byte = (k_q == 2'd0);
            MaskHalf: last_byte = (k_q == 2'd1);
            default:  last_byte = (k_q == 2'd3);
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        wd_d        = wd_q;
        mask_d      = mask_q;
        ext_d       = ext_q;
        k_d         = k_q;
        asm_d       = asm_q;
        rd_d        = rd_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
        mis_d       = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (i_req) begin
                    we_d   = i_we;
                    wd_d   = i_wd;
                    mask_d = i_mask_type;
                    ext_d  = i_ext_type;
                    k_d    = 2'd0;
                    asm_d  = 32'd0;
                    busy_d = 1'b1;
                    if (i_mask_type == MaskBad) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        rd_d    = 32'd0;
                    end else if (trap) begin
                        state_d = StDone;
                        done_d  = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
                        mis_d   = 1'b1;
`endif
                    end else begin
                        state_d     = StAccess;
                        mem_req_d   = 1'b1;
                        mem_we_d    = i_we;
                        mem_addr_d  = i_addr;
                        mem_wdata_d = i_wd[7:0];
                    end
                end
            end
            StAccess: begin
                if (i_mem_ready) begin
                    if (!we_q) begin
                        asm_d[{k_q, 3'b000} +: 8] = i_mem_rdata;
                    end
                    if (last_byte) begin
                        state_d     = StDone;
                        done_d      = 1'b1;
                        mem_req_d   = 1'b0;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = '0;
                        mem_wdata_d = 8'd0;
                        if (!we_q) begin
                            rd_d = extend(asm_d, mask_q, ext_q);
                        end
                    end else begin
                        k_d         = k_q + 2'd1;
                        // Address wraps modulo 2^ADDR_W by construction.
                        mem_addr_d  = mem_addr_q + ADDR_W'(1);
                        mem_wdata_d = wd_q[{k_d, 3'b000} +: 8];
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            wd_q        <= 32'd0;
            mask_q      <= 2'b00;
            ext_q       <= 1'b0;
            k_q         <= 2'd0;
            asm_q       <= 32'd0;
            rd_q        <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'd0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            wd_q        <= wd_d;
            mask_q      <= mask_d;
            ext_q       <= ext_d;
            k_q         <= k_d;
            asm_q       <= asm_d;
            rd_q        <= rd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q       <= mis_d;
`endif
        end
    end

    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_rd        = rd_q;
    assign o_mem_req   = mem_req_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;

endmodule
